dff_bank_arbiter: RTL and testbench
===================================

Name: dff_bank_arbiter

Overview:
Controller that shares one WIDTH-bit bank of D flip-flops (each with data, clk, s, r inputs and q/qn outputs) between two requesters. It grants access round-robin and turns each request (load, masked set, masked clear, read) into correctly timed bank strobes. It then samples the bank and returns the post-operation value with a one-cycle ack. It sits between the chip-level logic and the flip-flop array.

Parameters:
WIDTH, 8, bank width in bits
PULSE_CYCLES, 1, cycles the clk/s/r strobes are held high (>=1)

Ports:
clk  input  1  system clock, rising edge
r  input  1  synchronous, active-high reset
req0  input  1  requester 0 request (level, held until ack0)
op0  input  2  requester 0 op: 00 LOAD, 01 SET, 10 CLEAR, 11 READ
wdata0  input  WIDTH  requester 0 data (LOAD) or bit mask (SET/CLEAR)
ack0  output  1  one-cycle completion pulse to requester 0
req1  input  1  requester 1 request
op1  input  2  requester 1 op
wdata1  input  WIDTH  requester 1 data/mask
ack1  output  1  one-cycle completion pulse to requester 1
rd_data  output  WIDTH  bank value sampled after the granted op
busy  output  1  high in any state other than IDLE
grant  output  1  owner of the current/last transaction (0 or 1)
bank_data  output  WIDTH  D inputs of the bank
bank_clk  output  1  shared bank clock strobe
bank_s  output  WIDTH  per-bit set strobes
bank_r  output  WIDTH  per-bit reset strobes
bank_q  input  WIDTH  bank Q outputs

Behaviour:
- The single clock is clk. Reset is r: synchronous, active-high. All outputs are registered.
- Reset values: ack0/ack1=0, rd_data=0, busy=0, grant=0, bank_data=0, bank_clk=0, bank_s=0, bank_r=0, FSM=IDLE, last-served pointer=1 (so requester 0 wins first).
- FSM states: IDLE -> EXEC -> SETTLE -> DONE -> IDLE.
- IDLE: samples the eligible requests.
  - A requester whose ack was high in the previous cycle is ineligible (one-cycle guard).
  - One eligible request: grant it.
  - Both eligible: grant the one not served last.
  - On grant, latch op/wdata and set grant, then go to EXEC.
- EXEC lasts PULSE_CYCLES cycles, using a down-counter. Strobes are high for the whole state:
  - LOAD: bank_data=wdata, bank_clk=1.
  - SET: bank_s=wdata.
  - CLEAR: bank_r=wdata.
  - READ: no strobes.
  - bank_s and bank_r are never both high on the same bit.
- SETTLE: all strobes go to 0, bank_data is held. At the end of SETTLE, rd_data<=bank_q. Go to DONE.
- DONE: the granted requester's ack is high for exactly one cycle, the last-served pointer is updated, then go to IDLE.
- Latency: from the edge where the request is accepted, ack is high PULSE_CYCLES+2 edges later. Minimum accept-to-accept spacing is PULSE_CYCLES+3 cycles.
- Requester rules: hold req/op/wdata stable until ack; drop req in the cycle after ack. Changes to a latched request while busy are ignored.
- Mask of 0 for SET/CLEAR: legal. No strobes, the transaction still completes with ack.
- Reset mid-transaction: on the next edge, strobes=0 and FSM=IDLE. No ack is issued for the aborted op. The pointer returns to the reset value.

Optional Feature:
Macro DFF_BANK_QN_CHECK_EN.
- Defined: adds input bank_qn[WIDTH] and output err (1 bit, reset 0).
  - At the end of SETTLE, if bank_q != ~bank_qn, err is set and stays high until r.
  - The ack is still issued normally.
- Undefined: neither port exists and no check logic is built.

Test Plan:
1. WIDTH=8, PULSE_CYCLES=1, bank model attached. After r, req0 LOAD 0xA5 -> bank_clk high 1 cycle with bank_data=0xA5; ack0 pulses 3 edges after accept; rd_data=0xA5; busy low afterwards.
2. Bank=0xA5. req0 CLEAR 0x0F and req1 SET 0xF0 asserted on the same cycle -> req0 served first: bank_r=0x0F, ack0, rd_data=0xA0. Then req1: bank_s=0xF0, ack1, rd_data=0xF0.
3. Both req held continuously with READ, 6 transactions -> grant sequence 0,1,0,1,0,1; each ack exactly one cycle; no strobes; rd_data equals bank_q.
4. PULSE_CYCLES=3, req1 SET 0x81 -> bank_s=0x81 for exactly 3 cycles; ack1 5 edges after accept.
5. r asserted during EXEC of a req1 LOAD 0xFF -> strobes 0 next cycle; no ack1; the next simultaneous request is granted to req0.
6. DFF_BANK_QN_CHECK_EN defined, bank_qn forced equal to bank_q, READ -> err=1 after SETTLE and stays 1 through later transactions until r. With a correct qn, err stays 0.

Source files
------------

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter driving a shared D flip-flop bank for two requesters.
// Define DFF_BANK_QN_CHECK_EN to add the bank_qn input and sticky err output.
module dff_bank_arbiter #(
    parameter int WIDTH        = 8,
    parameter int PULSE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] wdata0,
    output logic             ack0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack1,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             grant,
    output logic [WIDTH-1:0] bank_data,
    output logic             bank_clk,
    output logic [WIDTH-1:0] bank_s,
    output logic [WIDTH-1:0] bank_r,
    input  logic [WIDTH-1:0] bank_q
`ifdef DFF_BANK_QN_CHECK_EN
    ,
    input  logic [WIDTH-1:0] bank_qn,
    output logic             err
`endif
);

    localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(PULSE_CYCLES - 1);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SETTLE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             last_q, last_d;
    logic             grant_q, grant_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic [WIDTH-1:0] bdata_q, bdata_d;
    logic             bclk_q, bclk_d;
    logic [WIDTH-1:0] bs_q, bs_d;
    logic [WIDTH-1:0] br_q, br_d;
    logic             el0, el1, pick;
`ifdef DFF_BANK_QN_CHECK_EN
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        grant_d = grant_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        rd_d    = rd_q;
        bdata_d = bdata_q;
        bclk_d  = 1'b0;
        bs_d    = '0;
        br_d    = '0;
`ifdef DFF_BANK_QN_CHECK_EN
        err_d   = err_q;
`endif
        // A requester just acked may still hold req for one cycle.
        el0  = req0 & ~ack0_q;
        el1  = req1 & ~ack1_q;
        pick = (el0 & el1) ? ~last_q : el1;

        unique case (state_q)
            IDLE: begin
                if (el0 | el1) begin
                    grant_d = pick;
                    op_d    = pick ? op1 : op0;
                    wdata_d = pick ? wdata1 : wdata0;
                    cnt_d   = CNT_INIT;
                    state_d = EXEC;
                    unique case (op_d)
                        OP_LOAD: begin
                            bdata_d = wdata_d;
                            bclk_d  = 1'b1;
                        end
                        OP_SET:   bs_d = wdata_d;
                        OP_CLEAR: br_d = wdata_d;
                        default:  ;
                    endcase
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d = SETTLE;
                end else begin
                    cnt_d  = cnt_q - CW'(1);
                    bclk_d = bclk_q;
                    bs_d   = bs_q;
                    br_d   = br_q;
                end
            end
            SETTLE: begin
                rd_d    = bank_q;
`ifdef DFF_BANK_QN_CHECK_EN
                if (bank_q != ~bank_qn) err_d = 1'b1;
`endif
                state_d = DONE;
            end
            DONE: begin
                ack0_d  = ~grant_q;
                ack1_d  = grant_q;
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            rd_q    <= '0;
            bdata_q <= '0;
            bclk_q  <= 1'b0;
            bs_q    <= '0;
            br_q    <= '0;
`ifdef DFF_BANK_QN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            bdata_q <= bdata_d;
            bclk_q  <= bclk_d;
            bs_q    <= bs_d;
            br_q    <= br_d;
`ifdef DFF_BANK_QN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rd_data   = rd_q;
    assign busy      = busy_q;
    assign grant     = grant_q;
    assign bank_data = bdata_q;
    assign bank_clk  = bclk_q;
    assign bank_s    = bs_q;
    assign bank_r    = br_q;
`ifdef DFF_BANK_QN_CHECK_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: a PULSE_CYCLES=1 instance driven from
// a vector table plus hand sequences, and a PULSE_CYCLES=3 instance.
module tb_dff_bank_arbiter;

    localparam logic [1:0] LD = 2'b00;
    localparam logic [1:0] ST = 2'b01;
    localparam logic [1:0] CL = 2'b10;
    localparam logic [1:0] RD = 2'b11;

    typedef struct {
        logic       r0;
        logic [1:0] o0;
        logic [7:0] w0;
        logic       r1;
        logic [1:0] o1;
        logic [7:0] w1;
        logic       first;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    logic       clk = 1'b0;
    logic       r = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] op0 = 2'b00, op1 = 2'b00;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, busy, grant, bank_clk;
    logic [7:0] rd_data, bank_data, bank_s, bank_r;
    logic [7:0] bm_q = '0;

    logic       t3_req1 = 1'b0;
    logic [1:0] t3_op1 = 2'b00;
    logic [7:0] t3_wdata1 = '0;
    logic       t3_ack0, t3_ack1, t3_busy, t3_grant, t3_bclk;
    logic [7:0] t3_rd, t3_bdata, t3_bs, t3_br;
    logic [7:0] bm3_q = '0;

`ifdef DFF_BANK_QN_CHECK_EN
    logic       qn_bad = 1'b0;
    logic       err, t3_err;
    logic [7:0] bank_qn;
    assign bank_qn = qn_bad ? bm_q : ~bm_q;
`endif

    int tests = 0;
    int failed = 0;
    vec_t vecs[10];

    always #5 clk = ~clk;

    // Behavioural bank: clk strobe loads D, s/r strobes set/clear bits.
    always @(posedge clk) begin
        bm_q  <= bank_clk ? bank_data : ((bm_q | bank_s) & ~bank_r);
        bm3_q <= t3_bclk ? t3_bdata : ((bm3_q | t3_bs) & ~t3_br);
    end

    dff_bank_arbiter #(.WIDTH(8), .PULSE_CYCLES(1)) u0 (
        .clk(clk), .r(r),
        .req0(req0), .op0(op0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .op1(op1), .wdata1(wdata1), .ack1(ack1),
        .rd_data(rd_data), .busy(busy), .grant(grant),
        .bank_data(bank_data), .bank_clk(bank_clk),
        .bank_s(bank_s), .bank_r(bank_r), .bank_q(bm_q)
`ifdef DFF_BANK_QN_CHECK_EN
        , .bank_qn(bank_qn), .err(err)
`endif
    );

    dff_bank_arbiter #(.WIDTH(8), .PULSE_CYCLES(3)) u3 (
        .clk(clk), .r(r),
        .req0(1'b0), .op0(2'b00), .wdata0(8'h00), .ack0(t3_ack0),
        .req1(t3_req1), .op1(t3_op1), .wdata1(t3_wdata1), .ack1(t3_ack1),
        .rd_data(t3_rd), .busy(t3_busy), .grant(t3_grant),
        .bank_data(t3_bdata), .bank_clk(t3_bclk),
        .bank_s(t3_bs), .bank_r(t3_br), .bank_q(bm3_q)
`ifdef DFF_BANK_QN_CHECK_EN
        , .bank_qn(~bm3_q), .err(t3_err)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        r = 1'b1;
        tick();
        tick();
        r = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic d0, d1, bprev, ov;
        int   n, acc;
        d0 = !v.r0;
        d1 = !v.r1;
        n = 0;
        acc = 0;
        ov = 1'b0;
        bprev = busy;
        req0 = v.r0; op0 = v.o0; wdata0 = v.w0;
        req1 = v.r1; op1 = v.o1; wdata1 = v.w1;
        for (int cyc = 0; cyc < 40 && !(d0 && d1); cyc++) begin
            tick();
            if (busy && !bprev) acc = cyc;
            bprev = busy;
            ov |= |(bank_s & bank_r);
            if (ack0 || ack1) begin
                chk($sformatf("v%0d_grant", idx), grant,
                    n == 0 ? v.first : !v.first);
                chk($sformatf("v%0d_latency", idx), cyc - acc, 3);
                if (ack0) begin
                    chk($sformatf("v%0d_rd0", idx), rd_data, v.e0);
                    req0 = 1'b0;
                    d0 = 1'b1;
                end
                if (ack1) begin
                    chk($sformatf("v%0d_rd1", idx), rd_data, v.e1);
                    req1 = 1'b0;
                    d1 = 1'b1;
                end
                n++;
            end
        end
        chk($sformatf("v%0d_done", idx), {d0, d1}, 2'b11);
        chk($sformatf("v%0d_s_r_overlap", idx), ov, 0);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{1'b1, CL, 8'h0F, 1'b1, ST, 8'hF0, 1'b0, 8'hA0, 8'hF0};
        vecs[1] = '{1'b0, RD, 8'h00, 1'b1, LD, 8'h3C, 1'b1, 8'h00, 8'h3C};
        vecs[2] = '{1'b1, RD, 8'h00, 1'b1, RD, 8'h00, 1'b0, 8'h3C, 8'h3C};
        vecs[3] = '{1'b1, ST, 8'h00, 1'b0, RD, 8'h00, 1'b0, 8'h3C, 8'h00};
        vecs[4] = '{1'b0, RD, 8'h00, 1'b1, CL, 8'h00, 1'b1, 8'h00, 8'h3C};
        vecs[5] = '{1'b1, LD, 8'h55, 1'b1, ST, 8'h0A, 1'b0, 8'h55, 8'h5F};
        vecs[6] = '{1'b1, ST, 8'h81, 1'b1, CL, 8'hFF, 1'b0, 8'hDF, 8'h00};
        vecs[7] = '{1'b1, RD, 8'h00, 1'b0, RD, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[8] = '{1'b1, LD, 8'h11, 1'b1, LD, 8'h22, 1'b1, 8'h11, 8'h22};
        vecs[9] = '{1'b1, RD, 8'h00, 1'b1, RD, 8'h00, 1'b0, 8'hFF, 8'hFF};

        tick();
        do_reset();
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_bank_data", bank_data, 0);
        chk("rst_bank_clk", bank_clk, 0);
        chk("rst_bank_s", bank_s, 0);
        chk("rst_bank_r", bank_r, 0);

        // LOAD 0xA5 traced edge by edge.
        req0 = 1'b1; op0 = LD; wdata0 = 8'hA5;
        tick();
        chk("t1_busy_exec", busy, 1);
        chk("t1_bank_clk_hi", bank_clk, 1);
        chk("t1_bank_data", bank_data, 8'hA5);
        chk("t1_grant", grant, 0);
        tick();
        chk("t1_bank_clk_lo", bank_clk, 0);
        chk("t1_bank_data_hold", bank_data, 8'hA5);
        chk("t1_ack0_early1", ack0, 0);
        tick();
        chk("t1_ack0_early2", ack0, 0);
        chk("t1_rd_data", rd_data, 8'hA5);
        tick();
        chk("t1_ack0", ack0, 1);
        chk("t1_busy_done", busy, 0);
        req0 = 1'b0;
        tick();
        chk("t1_ack0_one_cycle", ack0, 0);

        // Pointer back to reset so the first contended grant goes to req0.
        do_reset();
        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        begin : t3_rr
            int   k;
            logic pa, stb;
            do_reset();
            k = 0; pa = 1'b0; stb = 1'b0;
            req0 = 1'b1; op0 = RD; req1 = 1'b1; op1 = RD;
            for (int c = 0; c < 80 && k < 6; c++) begin
                tick();
                stb |= bank_clk | (|bank_s) | (|bank_r);
                if (ack0 || ack1) begin
                    chk("t3_ack_one_cycle", pa, 0);
                    chk("t3_grant_seq", grant, k % 2);
                    chk("t3_ack_owner", {ack1, ack0}, (k % 2) ? 2 : 1);
                    chk("t3_rd_eq_q", rd_data, bm_q);
                    k++;
                end
                pa = ack0 | ack1;
            end
            req0 = 1'b0; req1 = 1'b0;
            chk("t3_count", k, 6);
            chk("t3_no_strobes", stb, 0);
            tick();
        end

        begin : t4_pulse3
            int   acc, scnt;
            logic done, bprev, a0;
            acc = 0; scnt = 0; done = 1'b0; bprev = 1'b0; a0 = 1'b0;
            t3_req1 = 1'b1; t3_op1 = ST; t3_wdata1 = 8'h81;
            for (int c = 0; c < 30 && !done; c++) begin
                tick();
                if (t3_busy && !bprev) acc = c;
                bprev = t3_busy;
                a0 |= t3_ack0;
                if (t3_bs == 8'h81) scnt++;
                if (t3_ack1) begin
                    chk("t4_latency", c - acc, 5);
                    chk("t4_rd_data", t3_rd, 8'h81);
                    chk("t4_grant", t3_grant, 1);
                    t3_req1 = 1'b0;
                    done = 1'b1;
                end
            end
            chk("t4_done", done, 1);
            chk("t4_s_cycles", scnt, 3);
            chk("t4_no_ack0", a0, 0);
        end

        begin : t5_abort
            logic seen;
            seen = 1'b0;
            req1 = 1'b1; op1 = LD; wdata1 = 8'hFF;
            tick();
            chk("t5_exec_busy", busy, 1);
            chk("t5_exec_clk", bank_clk, 1);
            r = 1'b1; req1 = 1'b0;
            tick();
            r = 1'b0;
            chk("t5_clk_off", bank_clk, 0);
            chk("t5_s_off", bank_s, 0);
            chk("t5_r_off", bank_r, 0);
            chk("t5_idle", busy, 0);
            for (int c = 0; c < 5; c++) begin
                tick();
                seen |= ack0 | ack1;
            end
            chk("t5_no_ack", seen, 0);
            run_vec(vecs[9], 9);
        end

`ifdef DFF_BANK_QN_CHECK_EN
        chk("t6_err_clean", err, 0);
        qn_bad = 1'b1;
        run_vec('{1'b1, RD, 8'h00, 1'b0, RD, 8'h00, 1'b0, 8'hFF, 8'h00}, 10);
        chk("t6_err_set", err, 1);
        qn_bad = 1'b0;
        run_vec('{1'b0, RD, 8'h00, 1'b1, RD, 8'h00, 1'b1, 8'h00, 8'hFF}, 11);
        chk("t6_err_sticky", err, 1);
        chk("t6_t3_err", t3_err, 0);
        do_reset();
        chk("t6_err_reset", err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
